// File: rtl/apb_bridge_master_arbiter_if.sv
// Bundle of the requester-side REQ/DONE handshake and the AHB-slave-side
// bridge signals shared by apb_bridge_master_arbiter and its environment.
//   slave  : arbiter view. It takes the master requests and the bridge
//            responses, and drives DONE/grant plus the bridge address and data phases.
//   master : environment view (requesters + bridge), the mirror of slave.
interface apb_bridge_master_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TRAN_WIDTH  = 3
);
  // requester side
  logic [NUM_MASTERS-1:0]            M_REQ;
  logic [NUM_MASTERS-1:0]            M_WRITE;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ADDR;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_WDATA;
  logic [NUM_MASTERS-1:0]            M_DONE;
  logic                              M_ERR;
  logic [DATA_WIDTH-1:0]             M_RDATA;
  logic [NUM_MASTERS-1:0]            M_GRANT;
  // bridge side
  logic                              H_SEL_APB;
  logic [TRAN_WIDTH-1:0]             H_TRANS;
  logic                              H_WRITE;
  logic [ADDR_WIDTH-1:0]             H_ADDR;
  logic [DATA_WIDTH-1:0]             H_WDATA;
  logic                              H_READY_IN;
  logic                              H_READY_OUT;
  logic                              H_RESP;
  logic [DATA_WIDTH-1:0]             H_RDATA;

  modport slave (
    input  M_REQ, M_WRITE, M_ADDR, M_WDATA, H_READY_OUT, H_RESP, H_RDATA,
    output M_DONE, M_ERR, M_RDATA, M_GRANT,
           H_SEL_APB, H_TRANS, H_WRITE, H_ADDR, H_WDATA, H_READY_IN
  );

  modport master (
    output M_REQ, M_WRITE, M_ADDR, M_WDATA, H_READY_OUT, H_RESP, H_RDATA,
    input  M_DONE, M_ERR, M_RDATA, M_GRANT,
           H_SEL_APB, H_TRANS, H_WRITE, H_ADDR, H_WDATA, H_READY_IN
  );
endinterface

// File: rtl/apb_bridge_master_arbiter.sv
// Round-robin sequencer sharing one AHB-to-APB bridge between NUM_MASTERS
// requesters. Each transfer walks IDLE -> ADDR -> DATA -> RESP. A DATA phase
// that waits too long on H_READY_OUT is aborted with an error.
// Ports:
//   H_CLK    clock, rising edge
//   H_RESET  asynchronous active-high reset
//   bus      apb_bridge_master_arbiter_if.slave, carrying:
//              M_REQ/M_WRITE/M_ADDR/M_WDATA in, M_DONE/M_ERR/M_RDATA/M_GRANT out
//              H_SEL_APB/H_TRANS/H_WRITE/H_ADDR/H_WDATA/H_READY_IN out
//              H_READY_OUT/H_RESP/H_RDATA in
// All outputs are decoded from registered state only.
module apb_bridge_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TRAN_WIDTH  = 3,
  parameter int TIMEOUT     = 16
) (
  input logic                        H_CLK,
  input logic                        H_RESET,
  apb_bridge_master_arbiter_if.slave bus
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]         CNT_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [TRAN_WIDTH-1:0] TR_IDLE   = '0;
  localparam logic [TRAN_WIDTH-1:0] TR_NONSEQ = TRAN_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_gnt;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  logic [NUM_MASTERS-1:0]  w_rot;
  logic                    w_found;
  logic [IW-1:0]           w_pick;
  logic [IW:0]             w_sum;
  logic                    w_timeout;
  logic [NUM_MASTERS-1:0]  w_gnt_oh;

  // Rotate the request vector so bit 0 is the master at r_ptr; the first set
  // bit then gives the offset from r_ptr, folded back modulo NUM_MASTERS.
  always_comb begin
    w_rot   = NUM_MASTERS'({bus.M_REQ, bus.M_REQ} >> r_ptr);
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IW+1)'(i);
        if (w_sum >= (IW+1)'(NUM_MASTERS))
          w_sum = w_sum - (IW+1)'(NUM_MASTERS);
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge H_CLK or posedge H_RESET) begin
    if (H_RESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // H_READY_OUT has priority over the timeout when both land on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_ADDR;
      S_ADDR: w_state_nxt = S_DATA;
      S_DATA: begin
        if (bus.H_READY_OUT) begin
          w_state_nxt = S_RESP;
        end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge H_CLK or posedge H_RESET) begin
    if (H_RESET) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_gnt   <= w_pick;
            r_write <= bus.M_WRITE[w_pick];
            r_addr  <= bus.M_ADDR[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= bus.M_WDATA[w_pick*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_DATA: begin
          if (bus.H_READY_OUT) begin
            r_rdata <= bus.H_RDATA;
            r_err   <= bus.H_RESP;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (r_gnt == IW'(NUM_MASTERS - 1)) r_ptr <= '0;
          else                               r_ptr <= r_gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_gnt_oh = NUM_MASTERS'(1) << r_gnt;

  always_comb begin
    bus.M_DONE     = '0;
    bus.M_ERR      = 1'b0;
    bus.M_RDATA    = '0;
    bus.M_GRANT    = '0;
    bus.H_SEL_APB  = 1'b0;
    bus.H_TRANS    = TR_IDLE;
    bus.H_WRITE    = 1'b0;
    bus.H_ADDR     = '0;
    bus.H_WDATA    = '0;
    bus.H_READY_IN = 1'b0;
    case (r_state)
      S_ADDR: begin
        bus.M_GRANT    = w_gnt_oh;
        bus.H_SEL_APB  = 1'b1;
        bus.H_TRANS    = TR_NONSEQ;
        bus.H_WRITE    = r_write;
        bus.H_ADDR     = r_addr;
        bus.H_WDATA    = r_wdata;
        bus.H_READY_IN = 1'b1;
      end
      S_DATA: begin
        bus.M_GRANT    = w_gnt_oh;
        bus.H_WDATA    = r_wdata;
        bus.H_READY_IN = 1'b1;
      end
      S_RESP: begin
        bus.M_GRANT    = w_gnt_oh;
        bus.M_DONE     = w_gnt_oh;
        bus.M_ERR      = r_err;
        bus.M_RDATA    = r_rdata;
      end
      default: ;
    endcase
  end

endmodule
